// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver: 2-flop synchronizer, mid-bit aligned 2-of-3 majority
// sampling, optional parity, 1 or 2 stop bits, single-entry output holding register.
module uart_rx_engine #(
  parameter int WORD_LENGTH = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   SerialDataIn,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun_err,
  output logic                   busy,
  output logic [2:0]             state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = 4;

  state_t                 state, state_n;
  logic [TW-1:0]          tick, tick_n;
  logic [BW-1:0]          bit_cnt, bit_n;
  logic [WORD_LENGTH-1:0] shreg, shreg_n;
  logic                   par_r, par_n;
  logic                   frm_r, frm_n;
  logic                   sync1, rxs, rxs_d1, rxs_d2;
  logic                   maj, done;
  logic                   tick_zero, tick_half, tick_last;

  // rxs_d2/rxs_d1 hold the line at ticks OVERSAMPLE-2/OVERSAMPLE-1 whenever tick is 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= 1'b1;
      rxs    <= 1'b1;
      rxs_d1 <= 1'b1;
      rxs_d2 <= 1'b1;
    end else begin
      sync1  <= SerialDataIn;
      rxs    <= sync1;
      rxs_d1 <= rxs;
      rxs_d2 <= rxs_d1;
    end
  end

  assign maj       = (rxs & rxs_d1) | (rxs & rxs_d2) | (rxs_d1 & rxs_d2);
  assign tick_zero = (tick == '0);
  assign tick_half = (tick == TW'(OVERSAMPLE / 2));
  assign tick_last = (tick == TW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_r   <= 1'b0;
      frm_r   <= 1'b0;
    end else begin
      state   <= state_n;
      tick    <= tick_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      par_r   <= par_n;
      frm_r   <= frm_n;
    end
  end

  // In START, bit_cnt marks the phase: 0 = before the mid-bit re-check, 1 = after it.
  always_comb begin
    state_n = state;
    tick_n  = tick_last ? '0 : tick + TW'(1);
    bit_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par_r;
    frm_n   = frm_r;
    done    = 1'b0;
    case (state)
      IDLE: begin
        tick_n = '0;
        bit_n  = '0;
        if (!rxs) begin
          state_n = START;
          par_n   = 1'b0;
          frm_n   = 1'b0;
        end
      end
      START: begin
        if (bit_cnt == '0) begin
          if (tick_half) begin
            if (rxs) begin
              state_n = IDLE;
            end else begin
              tick_n = '0;
              bit_n  = BW'(1);
            end
          end
        end else if (tick_last) begin
          state_n = DATA;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (tick_zero) begin
          shreg_n = {maj, shreg[WORD_LENGTH-1:1]};
          if (bit_cnt == BW'(WORD_LENGTH - 1)) begin
            bit_n   = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: begin
        if (tick_zero) begin
          par_n   = ((^shreg) ^ maj) != (PARITY_ODD != 0);
          state_n = STOP;
        end
      end
      STOP: begin
        if (tick_zero) begin
          frm_n = frm_r | ~maj;
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            done    = 1'b1;
            bit_n   = '0;
            state_n = (frm_r | ~maj) ? WAIT_IDLE : IDLE;
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end
      end
      WAIT_IDLE: begin
        tick_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Handshake: a frame is transferred in a cycle with rx_valid=1 and rx_ready=1; the
  // holding register frees on that edge and may be refilled by a completion on the same
  // edge. A completion that finds the register full and not being drained is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (done && (!rx_valid || rx_ready)) begin
        rx_data    <= shreg;
        parity_err <= par_r;
        frame_err  <= frm_n;
        rx_valid   <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (done && rx_valid && !rx_ready) begin
        overrun_err <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        overrun_err <= 1'b0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: three configurations share one serial line; a table of
// frames, hand-written corner sequences and randomized frames feed one scoreboard.
module tb_uart_rx_engine;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       line;
  logic       rx_ready;
  logic [7:0] rdata [3];
  logic       rv [3];
  logic       pe [3];
  logic       fe [3];
  logic       ov [3];
  logic       bz [3];
  logic [2:0] st [3];

  int         n_checks = 0;
  int         n_fail   = 0;
  int         sel      = 0;
  bit         rand_rdy = 1'b0;
  logic [9:0] exp_q [$];

  typedef struct {
    int         s;
    logic [7:0] d;
    logic       pbit;
    logic       st2;
    logic [7:0] exp_d;
    logic       exp_p;
    logic       exp_f;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  uart_rx_engine dut0 (
    .clk(clk), .reset(reset), .SerialDataIn(line), .rx_data(rdata[0]), .rx_valid(rv[0]),
    .rx_ready(rx_ready), .parity_err(pe[0]), .frame_err(fe[0]), .overrun_err(ov[0]),
    .busy(bz[0]), .state_dbg(st[0])
  );

  uart_rx_engine #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .SerialDataIn(line), .rx_data(rdata[1]), .rx_valid(rv[1]),
    .rx_ready(rx_ready), .parity_err(pe[1]), .frame_err(fe[1]), .overrun_err(ov[1]),
    .busy(bz[1]), .state_dbg(st[1])
  );

  uart_rx_engine #(.STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .SerialDataIn(line), .rx_data(rdata[2]), .rx_valid(rv[2]),
    .rx_ready(rx_ready), .parity_err(pe[2]), .frame_err(fe[2]), .overrun_err(ov[2]),
    .busy(bz[2]), .state_dbg(st[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input bit glitch);
    for (int i = 0; i < OS; i++) begin
      line = (glitch && i == OS / 2) ? ~b : b;
      tick();
    end
  endtask

  // Start bit, 8 data bits LSB first, parity only for dut1, second stop only for dut2.
  task automatic send_frame(input int s, input logic [7:0] d, input logic pbit,
                            input logic st2, input bit glitch);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], glitch);
    if (s == 1) drive_bit(pbit, 1'b0);
    drive_bit(1'b1, 1'b0);
    if (s == 2) drive_bit(st2, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    line  = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    repeat (4) tick();
  endtask

  // Scoreboard: every accepted frame of the selected instance is matched in order.
  always @(negedge clk) begin
    if (reset && rv[sel] && rx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: got %0h, none required", {fe[sel], pe[sel], rdata[sel]});
      end else begin
        check("frame", 32'({fe[sel], pe[sel], rdata[sel]}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int         busy_cnt;
    int         low_cnt;
    logic [7:0] d;
    logic       pbit;
    logic       perr;

    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
    vecs[4] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[5] = '{1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{2, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[8] = '{2, 8'hC3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};

    reset    = 1'b0;
    line     = 1'b1;
    rx_ready = 1'b1;
    tick();
    @(negedge clk);
    check("rst_data", 32'(rdata[0]), 0);
    check("rst_valid", 32'(rv[0]), 0);
    check("rst_perr", 32'(pe[0]), 0);
    check("rst_ferr", 32'(fe[0]), 0);
    check("rst_ovr", 32'(ov[0]), 0);
    check("rst_busy", 32'(bz[0]), 0);

    foreach (vecs[k]) begin
      do_reset();
      sel = vecs[k].s;
      exp_q.push_back({vecs[k].exp_f, vecs[k].exp_p, vecs[k].exp_d});
      send_frame(vecs[k].s, vecs[k].d, vecs[k].pbit, vecs[k].st2, 1'b0);
      line = 1'b1;
      repeat (OS * 2) tick();
      @(negedge clk);
      check("vec_drained", 32'(exp_q.size()), 0);
      check("vec_held_data", 32'(rdata[sel]), 32'(vecs[k].exp_d));
      check("vec_ovr", 32'(ov[sel]), 0);
    end

    // Short low glitch in IDLE: a false start, nothing reported.
    do_reset();
    sel = 0;
    line = 1'b0;
    repeat (4) tick();
    line = 1'b1;
    busy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bz[0]) busy_cnt++;
    end
    check("glitch_busy_bound", 32'(busy_cnt <= OS / 2 + 3), 1);
    check("glitch_busy_seen", 32'(busy_cnt > 0), 1);
    check("glitch_idle", 32'(bz[0]), 0);
    check("glitch_no_frame", 32'(rv[0]), 0);

    // Two stop bits, second one low, line then held low: stuck busy until release.
    do_reset();
    sel = 2;
    exp_q.push_back({1'b1, 1'b0, 8'h5A});
    send_frame(2, 8'h5A, 1'b0, 1'b0, 1'b0);
    low_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (!bz[2]) low_cnt++;
    end
    check("stop2_busy_while_low", 32'(low_cnt), 0);
    check("stop2_ferr_held", 32'(fe[2]), 1);
    tick();
    line = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("stop2_idle_after_release", 32'(bz[2]), 0);
    check("stop2_drained", 32'(exp_q.size()), 0);

    // Overrun: second frame dropped while the first is held.
    do_reset();
    sel = 0;
    rx_ready = 1'b0;
    exp_q.push_back({2'b00, 8'h11});
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0);
    repeat (OS) tick();
    @(negedge clk);
    check("ovr_held_data", 32'(rdata[0]), 32'h11);
    check("ovr_valid", 32'(rv[0]), 1);
    check("ovr_flag", 32'(ov[0]), 1);
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    @(negedge clk);
    check("ovr_valid_clear", 32'(rv[0]), 0);
    check("ovr_flag_clear", 32'(ov[0]), 0);
    check("ovr_drained", 32'(exp_q.size()), 0);
    tick();
    rx_ready = 1'b1;

    // Single-cycle inversion at the middle of every data bit.
    do_reset();
    sel = 0;
    exp_q.push_back({2'b00, 8'h3C});
    send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1);
    repeat (OS) tick();
    @(negedge clk);
    check("mid_glitch_drained", 32'(exp_q.size()), 0);

    // Reset in the middle of a frame clears everything at once.
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    line = 1'b1;
    repeat (OS / 2) tick();
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(bz[0]), 0);
    check("midrst_data", 32'(rdata[0]), 0);
    check("midrst_valid", 32'(rv[0]), 0);
    check("midrst_state", 32'(st[0]), 0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (OS * 2) tick();
    @(negedge clk);
    check("midrst_no_partial", 32'(rv[0]), 0);
    tick();
    exp_q.push_back({2'b00, 8'h81});
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b0);
    repeat (OS) tick();
    @(negedge clk);
    check("midrst_next_frame", 32'(exp_q.size()), 0);

    // Random words with a randomly stalling consumer.
    do_reset();
    sel = 0;
    rand_rdy = 1'b1;
    for (int n = 0; n < 16; n++) begin
      d = 8'($urandom);
      exp_q.push_back({2'b00, d});
      send_frame(0, d, 1'b0, 1'b1, 1'b0);
      repeat ($urandom_range(0, 20)) tick();
    end
    rand_rdy = 1'b0;
    tick();
    rx_ready = 1'b1;
    repeat (OS * 2) tick();
    @(negedge clk);
    check("rand_drained", 32'(exp_q.size()), 0);
    check("rand_no_overrun", 32'(ov[0]), 0);

    // Random words and parity bits; even parity wants an even count of ones overall.
    do_reset();
    sel = 1;
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom);
      pbit = 1'($urandom_range(0, 1));
      perr = ((($countones(d) + int'(pbit)) % 2) != 0);
      exp_q.push_back({1'b0, perr, d});
      send_frame(1, d, pbit, 1'b1, 1'b0);
      repeat ($urandom_range(0, 20)) tick();
    end
    repeat (OS * 2) tick();
    @(negedge clk);
    check("rand_par_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
